// File: rtl/pkt_rr_mux_4.sv
`timescale 1ns/1ps
// pkt_rr_mux_4
// Packet-granular round-robin mux: four Avalon-ST style packet sources share
// one registered streaming output. Arbitration happens only at packet
// boundaries (SOP), and the grant is held until the winner's EOP beat is
// accepted. The output register honours backpressure beat by beat.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   in_data/in_valid/in_sop/
//   in_eop/in_empty              per-input stream, input i at slice i
//   in_ready                     per-input ready, one-hot or zero
//   out_data/out_valid/out_sop/
//   out_eop/out_empty            registered muxed stream
//   out_ready                    downstream ready
//   cur_sel                      index of the currently granted input
//
// Optional build macro PKT_RR_MUX_STATS_EN adds:
//   pkt_cnt   per-input packets forwarded (32 bits each, saturating)
//   stall_cnt cycles with out_valid && !out_ready (saturating)
//   stats_clr synchronous clear of both counters, wins over increment
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | between packets; pick the next SOP requester after r_last
// S_LOCKED | forwarding the packet of input r_sel until its EOP is taken
module pkt_rr_mux_4 #(
  parameter int NUM_IN = 4,
  parameter int DWIDTH = 512,
  parameter int EWIDTH = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_IN*DWIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]        in_valid,
  input  logic [NUM_IN-1:0]        in_sop,
  input  logic [NUM_IN-1:0]        in_eop,
  input  logic [NUM_IN*EWIDTH-1:0] in_empty,
  output logic [NUM_IN-1:0]        in_ready,
  output logic [DWIDTH-1:0]        out_data,
  output logic                     out_valid,
  output logic                     out_sop,
  output logic                     out_eop,
  output logic [EWIDTH-1:0]        out_empty,
  input  logic                     out_ready,
`ifdef PKT_RR_MUX_STATS_EN
  output logic [NUM_IN*32-1:0]     pkt_cnt,
  output logic [31:0]              stall_cnt,
  input  logic                     stats_clr,
`endif
  output logic [1:0]               cur_sel
);

  localparam logic S_IDLE   = 1'b0;
  localparam logic S_LOCKED = 1'b1;

  logic              r_state;
  logic [1:0]        r_sel;
  logic [1:0]        r_last;
  logic              r_out_valid;
  logic              r_out_sop;
  logic              r_out_eop;
  logic [DWIDTH-1:0] r_out_data;
  logic [EWIDTH-1:0] r_out_empty;

  logic [NUM_IN-1:0] w_req;
  logic [1:0]        w_scan;
  logic [1:0]        w_win;
  logic              w_any;
  logic              w_can_load;
  logic              w_xfer;
  logic              w_sel_eop;
  logic [DWIDTH-1:0] w_sel_data;
  logic [EWIDTH-1:0] w_sel_empty;

  // Only a valid SOP beat counts as a request; a stray mid-packet beat seen
  // while idle simply stalls on its own input.
  assign w_req = in_valid & in_sop;

  // Rotating priority: scan last+1, last+2, ... wrapping through last itself.
  always_comb begin
    w_win  = r_last;
    w_any  = 1'b0;
    w_scan = r_last;
    for (int k = 1; k <= 4; k++) begin
      w_scan = r_last + k[1:0];
      if (!w_any && w_req[w_scan]) begin
        w_win = w_scan;
        w_any = 1'b1;
      end
    end
  end

  // The output register can take a new beat when empty or draining this cycle.
  assign w_can_load  = !r_out_valid || out_ready;
  assign w_xfer      = (r_state == S_LOCKED) && in_valid[r_sel] && w_can_load;
  assign w_sel_eop   = in_eop[r_sel];
  assign w_sel_data  = in_data[int'(r_sel)*DWIDTH +: DWIDTH];
  assign w_sel_empty = in_empty[int'(r_sel)*EWIDTH +: EWIDTH];

  always_comb begin
    in_ready = '0;
    if (r_state == S_LOCKED)
      in_ready[r_sel] = w_can_load;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sel       <= 2'd0;
      r_last      <= 2'd3;
      r_out_valid <= 1'b0;
      r_out_sop   <= 1'b0;
      r_out_eop   <= 1'b0;
      r_out_data  <= '0;
      r_out_empty <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_sel   <= w_win;
            r_state <= S_LOCKED;
          end
        end
        S_LOCKED: begin
          // Release on the EOP input handshake; the beat itself still
          // drains through the output register afterwards.
          if (w_xfer && w_sel_eop) begin
            r_last  <= r_sel;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // Drains in both states so a trailing EOP leaves while re-arbitrating.
      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_sop   <= in_sop[r_sel];
        r_out_eop   <= w_sel_eop;
        r_out_data  <= w_sel_data;
        r_out_empty <= w_sel_empty;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_sop   = r_out_sop;
  assign out_eop   = r_out_eop;
  assign out_data  = r_out_data;
  assign out_empty = r_out_empty;
  assign cur_sel   = r_sel;

`ifdef PKT_RR_MUX_STATS_EN
  logic [31:0] r_pkt_cnt [NUM_IN];
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst || stats_clr) begin
      for (int i = 0; i < NUM_IN; i++)
        r_pkt_cnt[i] <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_xfer && w_sel_eop && (r_pkt_cnt[r_sel] != '1))
        r_pkt_cnt[r_sel] <= r_pkt_cnt[r_sel] + 32'd1;
      if (r_out_valid && !out_ready && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  for (genvar g = 0; g < NUM_IN; g++) begin : g_pkt_cnt
    assign pkt_cnt[g*32 +: 32] = r_pkt_cnt[g];
  end
  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pkt_rr_mux_4.sv
`timescale 1ns/1ps
module tb_pkt_rr_mux_4;
  localparam int NI = 4;
  localparam int DW = 64;
  localparam int EW = 6;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NI*DW-1:0] in_data;
  logic [NI-1:0]    in_valid, in_sop, in_eop, in_ready;
  logic [NI*EW-1:0] in_empty;
  logic [DW-1:0]    out_data;
  logic             out_valid, out_sop, out_eop, out_ready;
  logic [EW-1:0]    out_empty;
  logic [1:0]       cur_sel;
`ifdef PKT_RR_MUX_STATS_EN
  logic [NI*32-1:0] pkt_cnt;
  logic [31:0]      stall_cnt;
  logic             stats_clr = 1'b0;
`endif

  pkt_rr_mux_4 #(.NUM_IN(NI), .DWIDTH(DW), .EWIDTH(EW)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
    .in_empty(in_empty), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_sop(out_sop),
    .out_eop(out_eop), .out_empty(out_empty), .out_ready(out_ready),
`ifdef PKT_RR_MUX_STATS_EN
    .pkt_cnt(pkt_cnt), .stall_cnt(stall_cnt), .stats_clr(stats_clr),
`endif
    .cur_sel(cur_sel)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
    int            src;
  } beat_t;

  beat_t src_q   [NI][$];  // what each source still has to send
  beat_t model_q [NI][$];  // reference copy, consumed by the RR model
  beat_t exp_q   [$];      // expected output beat order
  int    grant_q [$];      // expected packet-to-source grant order
  int    out_cyc [$];      // cycle stamps of accepted output beats
  bit    rdy_pat [$];
  int    model_last = 3;
  int    tests = 0;
  int    fails = 0;
  bit    mon_en = 1'b0;
  bit    gaps = 1'b0;
  bit    bp = 1'b0;

  task automatic check(input bit ok, input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic gen_pkt(input int s, input int len);
    for (int b = 0; b < len; b++) begin
      beat_t bt;
      bt.data  = {$urandom, $urandom};
      bt.sop   = (b == 0);
      bt.eop   = (b == len - 1);
      bt.empty = EW'($urandom_range(63));
      bt.src   = s;
      src_q[s].push_back(bt);
      model_q[s].push_back(bt);
    end
  endtask

  // Round-robin over the sources with a pending packet, one packet per grant.
  task automatic plan();
    int pick;
    while (1) begin
      pick = -1;
      for (int k = 1; k <= NI; k++) begin
        int idx;
        idx = (model_last + k) % NI;
        if (pick < 0 && model_q[idx].size() > 0) pick = idx;
      end
      if (pick < 0) break;
      grant_q.push_back(pick);
      model_last = pick;
      while (model_q[pick].size() > 0) begin
        beat_t bt;
        bt = model_q[pick].pop_front();
        exp_q.push_back(bt);
        if (bt.eop) break;
      end
    end
  endtask

  task automatic flush_all();
    for (int i = 0; i < NI; i++) begin
      src_q[i].delete();
      model_q[i].delete();
    end
    exp_q.delete();
    grant_q.delete();
    out_cyc.delete();
    rdy_pat.delete();
    model_last = 3;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    flush_all();
    @(negedge clk);
    @(negedge clk);
    check(out_valid == 1'b0 && out_sop == 1'b0 && out_eop == 1'b0,
          "reset_out_flags", 128'({out_valid, out_sop, out_eop}), 128'(0));
    check(out_data == '0 && out_empty == '0, "reset_out_fields",
          128'({out_data, out_empty}), 128'(0));
    check(in_ready == '0, "reset_in_ready", 128'(in_ready), 128'(0));
    check(cur_sel == 2'd0, "reset_cur_sel", 128'(cur_sel), 128'(0));
    rst = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || grant_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(exp_q.size() == 0 && grant_q.size() == 0, nm,
          128'(exp_q.size() + grant_q.size()), 128'(0));
    @(negedge clk);
  endtask

  // Source driver: advance on handshake, present the next beat #1 after the edge.
  initial begin
    bit [NI-1:0] fire;
    in_valid = '0; in_sop = '0; in_eop = '0; in_data = '0; in_empty = '0;
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      fire = in_valid & in_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
        if (fire[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        // SOP beats are never gapped so every pending packet requests at once.
        if (src_q[i].size() > 0 &&
            (src_q[i][0].sop || !gaps || $urandom_range(3) != 0)) begin
          in_valid[i] = 1'b1;
          in_sop[i]   = src_q[i][0].sop;
          in_eop[i]   = src_q[i][0].eop;
          in_data[i*DW +: DW]  = src_q[i][0].data;
          in_empty[i*EW +: EW] = src_q[i][0].empty;
        end else begin
          in_valid[i] = 1'b0;
          in_sop[i]   = 1'b0;
          in_eop[i]   = 1'b0;
        end
      end
      if (rdy_pat.size() > 0) out_ready = rdy_pat.pop_front();
      else if (bp)            out_ready = ($urandom_range(2) != 0);
      else                    out_ready = 1'b1;
    end
  end

  // Monitor / scoreboard.
  initial begin
    bit          prev_hold;
    logic [71:0] prev_out;
    logic [71:0] got;
    logic [71:0] expv;
    int          exp_src;
    prev_hold = 1'b0;
    prev_out  = '0;
    forever begin
      @(negedge clk);
      if (rst || !mon_en) begin
        prev_hold = 1'b0;
      end else begin
        exp_src = (grant_q.size() > 0) ? grant_q[0] : -1;
        check($countones(in_ready) <= 1, "in_ready_onehot", 128'(in_ready), 128'(0));
        if (exp_src < 0)
          check(in_ready == '0, "in_ready_idle", 128'(in_ready), 128'(0));
        else
          check((in_ready & ~(4'b0001 << exp_src)) == '0, "in_ready_lock",
                128'(in_ready), 128'(4'b0001 << exp_src));
        for (int j = 0; j < NI; j++) begin
          if (in_valid[j] && in_ready[j]) begin
            check(exp_src == j, "in_fire_src", 128'(j), 128'(exp_src));
            if (in_eop[j] && grant_q.size() > 0) void'(grant_q.pop_front());
          end
        end
        got = {out_data, out_sop, out_eop, out_empty};
        if (prev_hold)
          check(out_valid && got == prev_out, "out_hold", 128'({out_valid, got}),
                128'({1'b1, prev_out}));
        if (out_valid && out_ready) begin
          out_cyc.push_back(cyc);
          expv = '0;
          if (exp_q.size() > 0) begin
            beat_t e;
            e = exp_q.pop_front();
            expv = {e.data, e.sop, e.eop, e.empty};
            check(got == expv, "out_beat", 128'(got), 128'(expv));
          end else begin
            check(exp_q.size() > 0, "out_beat_extra", 128'(got), 128'(0));
          end
        end
        prev_hold = out_valid && !out_ready;
        prev_out  = got;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    do_reset();
    mon_en = 1'b1;

    // Single source, latency and cur_sel.
    @(negedge clk);
    c = cyc;
    out_cyc.delete();
    gen_pkt(2, 3);
    plan();
    while (cyc < c + 2) @(negedge clk);
    check(cur_sel == 2'd2, "single_cur_sel", 128'(cur_sel), 128'(2));
    drain("single_drain");
    check(out_cyc.size() == 3, "single_nbeats", 128'(out_cyc.size()), 128'(3));
    for (int k = 0; k < 3 && k < out_cyc.size(); k++)
      check(out_cyc[k] == c + 3 + k, "single_beat_cycle", 128'(out_cyc[k]), 128'(c + 3 + k));

    // All four requesting with single-beat packets.
    do_reset();
    @(negedge clk);
    c = cyc;
    out_cyc.delete();
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < NI; s++) gen_pkt(s, 1);
    plan();
    drain("rr_drain");
    check(out_cyc.size() == 8, "rr_nbeats", 128'(out_cyc.size()), 128'(8));
    if (out_cyc.size() > 0)
      check(out_cyc[0] == c + 3, "rr_first_cycle", 128'(out_cyc[0]), 128'(c + 3));
    for (int k = 0; k + 1 < out_cyc.size(); k++)
      check(out_cyc[k+1] - out_cyc[k] == 2, "rr_spacing",
            128'(out_cyc[k+1] - out_cyc[k]), 128'(2));

    // Input 1 mid-packet while others raise SOP.
    for (int v = 0; v < 3; v++) begin
      @(negedge clk);
      c = cyc;
      gen_pkt(1, 4);
      plan();
      while (cyc < c + 3) @(negedge clk);
      gen_pkt(0, 2);
      if (v == 0) gen_pkt(2, 1);
      if (v == 1) gen_pkt(3, 1);
      plan();
      drain("lock_drain");
    end

    // Backpressure pattern 1,0,0,1 on a 4-beat packet.
    @(negedge clk);
    c = cyc;
    out_cyc.delete();
    gen_pkt(0, 4);
    plan();
    rdy_pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    while (cyc < c + 4) @(negedge clk);
    check(in_ready[0] == 1'b0 && out_valid, "stall_ready_a", 128'({in_ready[0], out_valid}), 128'(1));
    @(negedge clk);
    check(in_ready[0] == 1'b0 && out_valid, "stall_ready_b", 128'({in_ready[0], out_valid}), 128'(1));
    drain("stall_drain");
    check(out_cyc.size() == 4, "stall_nbeats", 128'(out_cyc.size()), 128'(4));
    if (out_cyc.size() == 4) begin
      check(out_cyc[1] == c + 6, "stall_beat2_cycle", 128'(out_cyc[1]), 128'(c + 6));
      check(out_cyc[3] == c + 8, "stall_beat4_cycle", 128'(out_cyc[3]), 128'(c + 8));
    end

    // Reset during beat 2, then fresh requests.
    for (int v = 0; v < 2; v++) begin
      @(negedge clk);
      mon_en = 1'b0;
      c = cyc;
      gen_pkt(2, 4);
      while (cyc < c + 3) @(negedge clk);
      check(out_valid == 1'b1, "prerst_valid", 128'(out_valid), 128'(1));
      rst = 1'b1;
      flush_all();
      @(negedge clk);
      check(out_valid == 1'b0, "midrst_out_valid", 128'(out_valid), 128'(0));
      check(in_ready == '0, "midrst_in_ready", 128'(in_ready), 128'(0));
      check(cur_sel == 2'd0, "midrst_cur_sel", 128'(cur_sel), 128'(0));
      rst = 1'b0;
      mon_en = 1'b1;
      gen_pkt(3, 2);
      if (v == 1) gen_pkt(0, 1);
      plan();
      drain("postrst_drain");
    end

    // Randomized traffic with gaps and backpressure.
    gaps = 1'b1;
    bp = 1'b1;
    for (int r = 0; r < 6; r++) begin
      @(negedge clk);
      for (int s = 0; s < NI; s++) begin
        int n;
        n = $urandom_range(3);
        for (int p = 0; p < n; p++) gen_pkt(s, $urandom_range(1, 5));
      end
      plan();
      drain("rand_drain");
    end
    gaps = 1'b0;
    bp = 1'b0;

`ifdef PKT_RR_MUX_STATS_EN
    do_reset();
    @(negedge clk);
    for (int p = 0; p < 5; p++) gen_pkt(1, 1);
    plan();
    for (int k = 0; k < 10; k++) rdy_pat.push_back(1'b1);
    for (int k = 0; k < 7; k++)  rdy_pat.push_back(1'b0);
    drain("stats_drain");
    check(stall_cnt == 32'd7, "stats_stall", 128'(stall_cnt), 128'(7));
    check(pkt_cnt[63:32] == 32'd5, "stats_pkt1", 128'(pkt_cnt[63:32]), 128'(5));
    check(pkt_cnt[31:0] == 32'd0 && pkt_cnt[127:64] == '0, "stats_pkt_other",
          128'(pkt_cnt), 128'(64'd5 << 32));
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    check(stall_cnt == '0 && pkt_cnt == '0, "stats_clr", 128'({stall_cnt, pkt_cnt[63:32]}), 128'(0));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
